tl_ul_inflight_monitor: RTL and testbench
=========================================

// Module: tl_ul_inflight_monitor
// PURPOSE
//  Parametrised, stateful TL-UL protocol checker for one A/D channel pair, bound next to a master/slave port in sim.
//  Tracks outstanding requests per source ID and checks every D response against its A request.
//  Checks A-channel hold stability and per-request timeout; reports errors as outputs; optional $fatal.
// PARAMETERS
//  SOURCE_BITS  5     width of a_source/d_source; table depth N = 2**SOURCE_BITS
//  SIZE_BITS    4     width of a_size/d_size
//  TIMEOUT      1024  cycles from A fire to D fire before timeout error; 0 disables the age counters
//  FATAL_EN     1     1: $fatal on any error (ifndef SYNTHESIS); 0: report via ports only
// PORTS
//  clock        in   1            sole clock; all state on posedge
//  reset_n      in   1            asynchronous, active-low reset
//  a_valid      in   1            A channel valid
//  a_ready      in   1            A channel ready
//  a_opcode     in   3            0 PutFull, 1 PutPartial, 4 Get; others illegal
//  a_source     in   SOURCE_BITS  A source ID
//  a_size       in   SIZE_BITS    A log2 size
//  d_valid      in   1            D channel valid
//  d_ready      in   1            D channel ready
//  d_opcode     in   3            0 AccessAck, 1 AccessAckData
//  d_source     in   SOURCE_BITS  D source ID
//  d_size       in   SIZE_BITS    D log2 size
//  clr_err      in   1            sync clear of err_sticky
//  err_valid    out  1            one-cycle error pulse
//  err_code     out  3            error code, valid with err_valid
//  err_source   out  SOURCE_BITS  offending source ID, valid with err_valid
//  err_sticky   out  7            bit k-1 set when code k has ever fired
//  inflight_cnt out  SOURCE_BITS+1 requests currently outstanding
// BEHAVIOUR
//  Fires: a_fire = a_valid & a_ready; d_fire = d_valid & d_ready. TL-UL only: single beat per message.
//  Reset: pend table, ages, inflight_cnt, err_* and hold regs all 0. Reset mid-operation drops all state.
//   Any later D fire is ORPHAN.
//  Table per source: pend, exp_op (Get->1, Put*->0), size, age, tout_done.
//  Error codes (err_code 0 never driven):
//   1 DUP_SRC  a_fire, pend[a_source]=1, and not retired this cycle
//   2 ORPHAN_D d_fire, pend[d_source]=0
//   3 OP_MISM  d_fire, pend=1, d_opcode != exp_op
//   4 SZ_MISM  d_fire, pend=1, d_size != stored size
//   5 TIMEOUT  age of pending entry reaches TIMEOUT-1; reported once per request (tout_done)
//   6 BAD_AOP  a_fire with a_opcode not in {0,1,4}
//   7 A_UNSTBL a_valid & !a_ready last cycle; this cycle a_valid dropped or opcode/source/size changed
//  Same-cycle D fire and A fire, same source: D retires first, A allocates. No DUP. inflight_cnt unchanged.
//  DUP_SRC: entry keeps the original request; the new A is not recorded. BAD_AOP: A not recorded.
//  d_fire with code 3/4: entry still retires. Codes 3 and 4 together: 3 reported, both sticky bits set.
//  Several errors in one cycle: lowest code drives err_code/err_source; all sticky bits set.
//  Several timeouts in one cycle: lowest index reported; rest stay queued (tout_pend) and go out one per
//   cycle when no higher-priority error fires.
//  Outputs registered: err_* valid 1 cycle after the causing edge.
//  inflight_cnt +1 on recorded A, -1 on retired D, net 0 if both; never wraps (max N).
//  Age: clears on allocate, +1 per cycle while pend, saturates at TIMEOUT-1.
//  clr_err clears err_sticky; a same-cycle new error wins (bit set).
// STRUCTURE
//  Package tl_mon_pkg holds:
//   - tl_a_op_e and tl_d_op_e enums and the err_code_e enum
//   - function exp_d_op(a_op)
//   - ERR_W=3 constant
//  Sub-module tl_mon_src_entry: one per-source slot (pend/op/size/age/tout), generated N times.
//  Top: fire decode, hold-stability regs, priority encoder, counters.
// TESTING
//  Get src3 size2; AccessAckData src3 size2 after 5 cycles -> no error; inflight_cnt 1 then 0.
//  Two Gets src7 back-to-back, no D between -> err_code=1, err_source=7; inflight_cnt stays 1.
//  d_fire src9, nothing pending -> err_code=2; same cycle A src9 + D retire src9 -> no error.
//  PutFull src1; D AccessAckData size 3 vs stored 2 -> err_code=3, sticky bits 2 and 3 set; entry retires.
//  TIMEOUT=16, Gets src0 and src1 same age -> code 5 src0 at cycle 16, src1 next cycle; exactly once each.
//  a_valid=1, a_ready=0, source changes 4->5 next cycle -> err_code=7.
//  reset_n low mid-flight -> pend cleared; later D -> err_code=2.

Source files
------------

// File: rtl/tl_mon_pkg.sv
// Shared types and helpers for the TL-UL in-flight monitor.
// Opcode enums, error codes and the A-to-D opcode mapping.
package tl_mon_pkg;

  localparam int unsigned ERR_W = 3;
  localparam int unsigned OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [OP_W-1:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE     = 3'd0,
    ERR_DUP_SRC  = 3'd1,
    ERR_ORPHAN_D = 3'd2,
    ERR_OP_MISM  = 3'd3,
    ERR_SZ_MISM  = 3'd4,
    ERR_TIMEOUT  = 3'd5,
    ERR_BAD_AOP  = 3'd6,
    ERR_A_UNSTBL = 3'd7
  } err_code_e;

  // Response opcode a well-behaved slave returns for a given request opcode.
  function automatic tl_d_op_e exp_d_op(input logic [OP_W-1:0] a_op);
    return (a_op == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
  endfunction

  function automatic logic a_op_legal(input logic [OP_W-1:0] a_op);
    return (a_op == A_PUT_FULL) || (a_op == A_PUT_PARTIAL) || (a_op == A_GET);
  endfunction

endpackage

// File: rtl/tl_mon_src_entry.sv
// One outstanding-request slot: pending flag, expected response, size and age.
// Age saturates at TIMEOUT-1; the timeout request is raised once per allocation.
module tl_mon_src_entry #(
  parameter int unsigned SIZE_BITS = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 alloc,
  input  logic                 retire,
  input  logic                 alloc_exp_op,
  input  logic [SIZE_BITS-1:0] alloc_size,
  input  logic                 tout_ack,
  output logic                 pend_o,
  output logic                 exp_op_o,
  output logic [SIZE_BITS-1:0] size_o,
  output logic                 tout_req_c
);

  localparam int unsigned AGE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = (TIMEOUT > 0) ? AGE_W'(TIMEOUT - 1) : '0;
  localparam bit TOUT_EN = (TIMEOUT != 0);

  logic                 pend_q, pend_d;
  logic                 exp_op_q, exp_op_d;
  logic [SIZE_BITS-1:0] size_q, size_d;
  logic [AGE_W-1:0]     age_q, age_d;
  logic                 tout_done_q, tout_done_d;

  // A same-cycle allocate overrides the retire of the previous request.
  always_comb begin
    pend_d      = pend_q;
    exp_op_d    = exp_op_q;
    size_d      = size_q;
    age_d       = age_q;
    tout_done_d = tout_done_q;
    if (retire) begin
      pend_d = 1'b0;
    end
    if (alloc) begin
      pend_d      = 1'b1;
      exp_op_d    = alloc_exp_op;
      size_d      = alloc_size;
      age_d       = '0;
      tout_done_d = 1'b0;
    end else if (pend_q && TOUT_EN) begin
      if (age_q != AGE_MAX) begin
        age_d = age_q + AGE_W'(1);
      end
      if (tout_ack) begin
        tout_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= 1'b0;
      exp_op_q    <= 1'b0;
      size_q      <= '0;
      age_q       <= '0;
      tout_done_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      exp_op_q    <= exp_op_d;
      size_q      <= size_d;
      age_q       <= age_d;
      tout_done_q <= tout_done_d;
    end
  end

  assign pend_o     = pend_q;
  assign exp_op_o   = exp_op_q;
  assign size_o     = size_q;
  assign tout_req_c = TOUT_EN && pend_q && (age_q == AGE_MAX) && !tout_done_q;

endmodule

// File: rtl/tl_ul_inflight_monitor.sv
// TL-UL A/D checker: tracks outstanding requests per source and flags protocol errors.
// Errors are priority-encoded into a registered one-cycle pulse plus sticky bits.
module tl_ul_inflight_monitor
  import tl_mon_pkg::*;
#(
  parameter int unsigned SOURCE_BITS = 5,
  parameter int unsigned SIZE_BITS   = 4,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned FATAL_EN    = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [OP_W-1:0]        a_opcode,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [OP_W-1:0]        d_opcode,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic                   clr_err,
  output logic                   err_valid,
  output logic [ERR_W-1:0]       err_code,
  output logic [SOURCE_BITS-1:0] err_source,
  output logic [6:0]             err_sticky,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int unsigned N     = 1 << SOURCE_BITS;
  localparam int unsigned CNT_W = SOURCE_BITS + 1;

  logic a_fire, d_fire, a_hit, d_hit, same_src;
  logic alloc, retire, dup_err;
  logic [N-1:0] pend_vec, exp_vec, tout_req_vec, tout_cand, alloc_vec, retire_vec, tout_ack_vec;
  logic [SIZE_BITS-1:0] size_arr [N];
  logic [OP_W-1:0] d_exp_op;

  logic                   tout_any, tout_grant;
  logic [SOURCE_BITS-1:0] tout_idx;
  logic [6:0]             err_hit, sticky_set;

  logic                   a_hold_q, a_hold_d;
  logic [OP_W-1:0]        a_op_q, a_op_d;
  logic [SOURCE_BITS-1:0] a_src_q, a_src_d;
  logic [SIZE_BITS-1:0]   a_size_q, a_size_d;

  logic                   err_valid_q, err_valid_d;
  err_code_e              err_code_d;
  logic [ERR_W-1:0]       err_code_q;
  logic [SOURCE_BITS-1:0] err_source_q, err_source_d;
  logic [6:0]             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign a_fire   = a_valid & a_ready;
  assign d_fire   = d_valid & d_ready;
  assign a_hit    = pend_vec[a_source];
  assign d_hit    = pend_vec[d_source];
  assign same_src = (a_source == d_source);
  assign d_exp_op = exp_vec[d_source] ? OP_W'(D_ACCESS_ACK_DATA) : OP_W'(D_ACCESS_ACK);

  // D retires before A allocates, so a same-source A in the retire cycle is not a duplicate.
  assign retire  = d_fire & d_hit;
  assign dup_err = a_fire & a_hit & ~(retire & same_src);
  assign alloc   = a_fire & a_op_legal(a_opcode) & ~dup_err;

  for (genvar i = 0; i < int'(N); i++) begin : g_entry
    assign alloc_vec[i]    = alloc & (a_source == SOURCE_BITS'(i));
    assign retire_vec[i]   = retire & (d_source == SOURCE_BITS'(i));
    assign tout_cand[i]    = tout_req_vec[i] & ~retire_vec[i];
    assign tout_ack_vec[i] = tout_grant & (tout_idx == SOURCE_BITS'(i));

    tl_mon_src_entry #(
      .SIZE_BITS (SIZE_BITS),
      .TIMEOUT   (TIMEOUT)
    ) u_entry (
      .clock        (clock),
      .reset_n      (reset_n),
      .alloc        (alloc_vec[i]),
      .retire       (retire_vec[i]),
      .alloc_exp_op (exp_d_op(a_opcode) == D_ACCESS_ACK_DATA),
      .alloc_size   (a_size),
      .tout_ack     (tout_ack_vec[i]),
      .pend_o       (pend_vec[i]),
      .exp_op_o     (exp_vec[i]),
      .size_o       (size_arr[i]),
      .tout_req_c   (tout_req_vec[i])
    );
  end

  // Lowest-index expired entry; the others stay queued until granted.
  always_comb begin
    tout_any = 1'b0;
    tout_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (tout_cand[i]) begin
        tout_any = 1'b1;
        tout_idx = SOURCE_BITS'(i);
      end
    end
  end

  assign err_hit[0]  = dup_err;
  assign err_hit[1]  = d_fire & ~d_hit;
  assign err_hit[2]  = retire & (d_opcode != d_exp_op);
  assign err_hit[3]  = retire & (d_size != size_arr[d_source]);
  assign tout_grant  = tout_any & ~(|err_hit[3:0]);
  assign err_hit[4]  = tout_grant;
  assign err_hit[5]  = a_fire & ~a_op_legal(a_opcode);
  assign err_hit[6]  = a_hold_q & (~a_valid | (a_opcode != a_op_q) |
                                   (a_source != a_src_q) | (a_size != a_size_q));
  assign sticky_set  = err_hit | {2'b00, tout_any, 4'b0000};

  always_comb begin
    a_hold_d     = a_valid & ~a_ready;
    a_op_d       = a_opcode;
    a_src_d      = a_source;
    a_size_d     = a_size;
    err_valid_d  = 1'b1;
    err_code_d   = ERR_NONE;
    err_source_d = '0;
    if (err_hit[0]) begin
      err_code_d   = ERR_DUP_SRC;
      err_source_d = a_source;
    end else if (err_hit[1]) begin
      err_code_d   = ERR_ORPHAN_D;
      err_source_d = d_source;
    end else if (err_hit[2]) begin
      err_code_d   = ERR_OP_MISM;
      err_source_d = d_source;
    end else if (err_hit[3]) begin
      err_code_d   = ERR_SZ_MISM;
      err_source_d = d_source;
    end else if (err_hit[4]) begin
      err_code_d   = ERR_TIMEOUT;
      err_source_d = tout_idx;
    end else if (err_hit[5]) begin
      err_code_d   = ERR_BAD_AOP;
      err_source_d = a_source;
    end else if (err_hit[6]) begin
      err_code_d   = ERR_A_UNSTBL;
      err_source_d = a_src_q;
    end else begin
      err_valid_d  = 1'b0;
    end
    err_sticky_d = (clr_err ? 7'd0 : err_sticky_q) | sticky_set;
    cnt_d = cnt_q;
    if (alloc && !retire && (cnt_q != CNT_W'(N))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (retire && !alloc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_hold_q     <= 1'b0;
      a_op_q       <= '0;
      a_src_q      <= '0;
      a_size_q     <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_source_q <= '0;
      err_sticky_q <= '0;
      cnt_q        <= '0;
    end else begin
      a_hold_q     <= a_hold_d;
      a_op_q       <= a_op_d;
      a_src_q      <= a_src_d;
      a_size_q     <= a_size_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_source_q <= err_source_d;
      err_sticky_q <= err_sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_source   = err_source_q;
  assign err_sticky   = err_sticky_q;
  assign inflight_cnt = cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if ((FATAL_EN != 0) && err_valid_q) begin
      $fatal(1, "tl_ul_inflight_monitor: protocol error code %0d source %0d",
             err_code_q, err_source_q);
    end
  end
`endif

endmodule

// File: tb/tb_tl_ul_inflight_monitor.sv
// Directed bench for tl_ul_inflight_monitor: vector table plus timeout and reset sequences.
module tb_tl_ul_inflight_monitor;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid = 1'b0, a_ready = 1'b0;
  logic [2:0] a_opcode = '0;
  logic [4:0] a_source = '0;
  logic [3:0] a_size = '0;
  logic       d_valid = 1'b0, d_ready = 1'b0;
  logic [2:0] d_opcode = '0;
  logic [4:0] d_source = '0;
  logic [3:0] d_size = '0;
  logic       clr_err = 1'b0;
  logic       err_valid;
  logic [2:0] err_code;
  logic [4:0] err_source;
  logic [6:0] err_sticky;
  logic [5:0] inflight_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  tl_ul_inflight_monitor #(
    .SOURCE_BITS (5),
    .SIZE_BITS   (4),
    .TIMEOUT     (16),
    .FATAL_EN    (0)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_opcode     (a_opcode),
    .a_source     (a_source),
    .a_size       (a_size),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_opcode     (d_opcode),
    .d_source     (d_source),
    .d_size       (d_size),
    .clr_err      (clr_err),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .err_source   (err_source),
    .err_sticky   (err_sticky),
    .inflight_cnt (inflight_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic av, ar; logic [2:0] aop; logic [4:0] asrc; logic [3:0] asz;
    logic dv, dr; logic [2:0] dop; logic [4:0] dsrc; logic [3:0] dsz;
    logic clr;
    logic ev; logic [2:0] ecode; logic [4:0] esrc; logic [6:0] esticky; logic [5:0] ecnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic av, ar, input logic [2:0] aop, input logic [4:0] asrc, input logic [3:0] asz,
    input logic dv, dr, input logic [2:0] dop, input logic [4:0] dsrc, input logic [3:0] dsz,
    input logic clr,
    input logic ev, input logic [2:0] ecode, input logic [4:0] esrc,
    input logic [6:0] esticky, input logic [5:0] ecnt);
    vec_t v;
    v.av = av; v.ar = ar; v.aop = aop; v.asrc = asrc; v.asz = asz;
    v.dv = dv; v.dr = dr; v.dop = dop; v.dsrc = dsrc; v.dsz = dsz;
    v.clr = clr;
    v.ev = ev; v.ecode = ecode; v.esrc = esrc; v.esticky = esticky; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_idle();
    a_valid = 1'b0; a_ready = 1'b0; a_opcode = '0; a_source = '0; a_size = '0;
    d_valid = 1'b0; d_ready = 1'b0; d_opcode = '0; d_source = '0; d_size = '0;
    clr_err = 1'b0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [4:0] src, input logic [3:0] sz);
    a_valid = 1'b1; a_ready = 1'b1; a_opcode = op; a_source = src; a_size = sz;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [4:0] src, input logic [3:0] sz);
    d_valid = 1'b1; d_ready = 1'b1; d_opcode = op; d_source = src; d_size = sz;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Columns: A(v,r,op,src,sz)  D(v,r,op,src,sz)  clr | exp valid,code,src,sticky,cnt
    vecs[0]  = mk(0,0,0,0,0, 0,0,0,0,0,  0, 0,0,0, 7'h00,0);
    vecs[1]  = mk(1,1,4,3,2, 0,0,0,0,0,  0, 0,0,0, 7'h00,1);
    vecs[2]  = mk(0,0,0,0,0, 0,0,0,0,0,  0, 0,0,0, 7'h00,1);
    vecs[3]  = mk(0,0,0,0,0, 0,0,0,0,0,  0, 0,0,0, 7'h00,1);
    vecs[4]  = mk(0,0,0,0,0, 1,1,1,3,2,  0, 0,0,0, 7'h00,0);
    vecs[5]  = mk(1,1,4,7,0, 0,0,0,0,0,  0, 0,0,0, 7'h00,1);
    vecs[6]  = mk(1,1,4,7,0, 0,0,0,0,0,  0, 1,1,7, 7'h01,1);
    vecs[7]  = mk(0,0,0,0,0, 1,1,0,9,0,  0, 1,2,9, 7'h03,1);
    vecs[8]  = mk(1,1,0,9,1, 0,0,0,0,0,  0, 0,0,0, 7'h03,2);
    vecs[9]  = mk(1,1,4,9,0, 1,1,0,9,1,  0, 0,0,0, 7'h03,2);
    vecs[10] = mk(1,1,0,1,2, 0,0,0,0,0,  0, 0,0,0, 7'h03,3);
    vecs[11] = mk(0,0,0,0,0, 1,1,1,1,3,  0, 1,3,1, 7'h0F,2);
    vecs[12] = mk(0,0,0,0,0, 0,0,0,0,0,  1, 0,0,0, 7'h00,2);
    vecs[13] = mk(1,1,2,4,0, 0,0,0,0,0,  0, 1,6,4, 7'h20,2);
    vecs[14] = mk(1,0,0,4,0, 0,0,0,0,0,  0, 0,0,0, 7'h20,2);
    vecs[15] = mk(1,0,0,5,0, 0,0,0,0,0,  0, 1,7,4, 7'h60,2);
    vecs[16] = mk(0,0,0,0,0, 1,1,0,20,0, 1, 1,2,20,7'h42,2);
    vecs[17] = mk(0,0,0,0,0, 0,0,0,0,0,  0, 0,0,0, 7'h42,2);

    set_idle();
    #12;
    check("reset err_valid", 32'(err_valid), 32'd0);
    check("reset err_sticky", 32'(err_sticky), 32'd0);
    check("reset inflight_cnt", 32'(inflight_cnt), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      a_valid = vecs[i].av; a_ready = vecs[i].ar; a_opcode = vecs[i].aop;
      a_source = vecs[i].asrc; a_size = vecs[i].asz;
      d_valid = vecs[i].dv; d_ready = vecs[i].dr; d_opcode = vecs[i].dop;
      d_source = vecs[i].dsrc; d_size = vecs[i].dsz;
      clr_err = vecs[i].clr;
      step();
      check($sformatf("row%0d err_valid", i), 32'(err_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        check($sformatf("row%0d err_code", i), 32'(err_code), 32'(vecs[i].ecode));
        check($sformatf("row%0d err_source", i), 32'(err_source), 32'(vecs[i].esrc));
      end
      check($sformatf("row%0d err_sticky", i), 32'(err_sticky), 32'(vecs[i].esticky));
      check($sformatf("row%0d inflight_cnt", i), 32'(inflight_cnt), 32'(vecs[i].ecnt));
    end

    // Timeout: Gets on src0 then src1; an orphan D on src30 blocks the first report one cycle.
    set_idle();
    reset_n = 1'b0;
    step();
    @(negedge clock);
    reset_n = 1'b1;
    drive_a(3'd4, 5'd0, 4'd0);
    step();
    check("tout alloc src0 cnt", 32'(inflight_cnt), 32'd1);
    for (int k = 1; k <= 22; k++) begin
      logic       ev;
      logic [2:0] ec;
      logic [4:0] es;
      set_idle();
      if (k == 1)  drive_a(3'd4, 5'd1, 4'd0);
      if (k == 16) drive_d(3'd0, 5'd30, 4'd0);
      step();
      ev = 1'b1; ec = 3'd0; es = 5'd0;
      case (k)
        16:      begin ec = 3'd2; es = 5'd30; end
        17:      begin ec = 3'd5; es = 5'd0;  end
        18:      begin ec = 3'd5; es = 5'd1;  end
        default: ev = 1'b0;
      endcase
      check($sformatf("tout k%0d err_valid", k), 32'(err_valid), 32'(ev));
      if (ev) begin
        check($sformatf("tout k%0d err_code", k), 32'(err_code), 32'(ec));
        check($sformatf("tout k%0d err_source", k), 32'(err_source), 32'(es));
      end
    end
    check("tout err_sticky", 32'(err_sticky), 32'h12);
    check("tout inflight_cnt", 32'(inflight_cnt), 32'd2);

    // Reset while src0/src1 are outstanding drops them; a later D is an orphan.
    set_idle();
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset inflight_cnt", 32'(inflight_cnt), 32'd0);
    check("midreset err_sticky", 32'(err_sticky), 32'd0);
    step();
    check("midreset err_valid", 32'(err_valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drive_d(3'd1, 5'd0, 4'd0);
    step();
    check("post-reset D err_valid", 32'(err_valid), 32'd1);
    check("post-reset D err_code", 32'(err_code), 32'd2);
    check("post-reset D err_source", 32'(err_source), 32'd0);
    check("post-reset D inflight_cnt", 32'(inflight_cnt), 32'd0);
    set_idle();
    step();
    check("post-reset idle err_valid", 32'(err_valid), 32'd0);
    check("post-reset idle err_sticky", 32'(err_sticky), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
